// File: rtl/hexdump_pkg.sv
// hexdump_pkg: shared state encoding and ASCII constants for the hex word streamer
package hexdump_pkg;
    typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIGIT, SEP} state_t;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_X    = 8'h78;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
endpackage

// File: rtl/hex_word_streamer_if.sv
// hex_word_streamer_if: word-in / character-out handshake bundle
interface hex_word_streamer_if #(parameter int DATA_WIDTH = 32);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [7:0]            out_char;
    logic                  out_ready;
    logic                  busy;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_char, busy);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_char, busy);
endinterface

// File: rtl/hextoascii.sv
// hextoascii: nibble to uppercase ASCII hex digit
module hextoascii (
    input  logic [3:0] hex,
    output logic [7:0] ascii
);
    always_comb ascii = (hex < 4'd10) ? 8'h30 + {4'h0, hex} : 8'h37 + {4'h0, hex};
endmodule

// File: rtl/hex_word_streamer.sv
// hex_word_streamer: word to MSB-first ASCII hex stream plus separator; HEX_WORD_STREAMER_PREFIX_EN adds a "0x" prefix
module hex_word_streamer import hexdump_pkg::*; #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [7:0] SEPARATOR  = ASCII_LF
) (
    input logic clk,
    input logic rst,
    hex_word_streamer_if.slave bus
);
    localparam int ND = DATA_WIDTH / 4;
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;
    state_t                state;
    logic [DATA_WIDTH-1:0] shift, nxt_shift;
    logic [CW-1:0]         cnt;
    logic [7:0]            digit;
    logic                  accept, hs;
    assign bus.in_ready = (state == IDLE) && !rst;
    assign bus.busy     = state != IDLE;
    assign accept       = bus.in_valid && bus.in_ready;
    assign hs           = bus.out_valid && bus.out_ready;
    // converter looks at the value the shift register is about to hold, so out_char can be registered
    always_comb nxt_shift = accept ? bus.in_data : (state == DIGIT && hs) ? shift << 4 : shift;
    hextoascii u_hex (.hex(nxt_shift[DATA_WIDTH-1 -: 4]), .ascii(digit));
    always_ff @(posedge clk)
        if (rst) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.out_char  <= 8'h00;
            shift         <= '0;
            cnt           <= '0;
        end else begin
            shift <= nxt_shift;
            case (state)
                IDLE: if (accept) begin
                    cnt           <= CW'(ND - 1);
                    bus.out_valid <= 1'b1;
`ifdef HEX_WORD_STREAMER_PREFIX_EN
                    state         <= PFX0;
                    bus.out_char  <= ASCII_ZERO;
`else
                    state         <= DIGIT;
                    bus.out_char  <= digit;
`endif
                end
`ifdef HEX_WORD_STREAMER_PREFIX_EN
                PFX0: if (hs) begin
                    state        <= PFX1;
                    bus.out_char <= ASCII_X;
                end
                PFX1: if (hs) begin
                    state        <= DIGIT;
                    bus.out_char <= digit;
                end
`endif
                DIGIT: if (hs) begin
                    cnt          <= cnt - 1'b1;
                    state        <= (cnt == '0) ? SEP : DIGIT;
                    bus.out_char <= (cnt == '0) ? SEPARATOR : digit;
                end
                SEP: if (hs) begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_hex_word_streamer.sv
// tb_hex_word_streamer: directed checks of the hex word streamer at widths 32, 8 and 4
module tb_hex_word_streamer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    always #5 clk = ~clk;
    hex_word_streamer_if #(.DATA_WIDTH(32)) b32 ();
    hex_word_streamer_if #(.DATA_WIDTH(8))  b8 ();
    hex_word_streamer_if #(.DATA_WIDTH(4))  b4 ();
    hex_word_streamer #(.DATA_WIDTH(32))                     u32 (.clk(clk), .rst(rst), .bus(b32));
    hex_word_streamer #(.DATA_WIDTH(8))                      u8  (.clk(clk), .rst(rst), .bus(b8));
    hex_word_streamer #(.DATA_WIDTH(4), .SEPARATOR(8'h20))   u4  (.clk(clk), .rst(rst), .bus(b4));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic send32(input logic [31:0] d);
        @(negedge clk);
        b32.in_valid = 1'b1;
        b32.in_data  = d;
        @(negedge clk);
        b32.in_valid = 1'b0;
    endtask
    // expects the first character at the current negedge; stall toggles out_ready 1,0,1,0...
    task automatic recv32(input string tag, input logic [7:0] exp[$], input bit stall, input bit inject);
        int k = 0;
        int n = stall ? 2 * exp.size() - 1 : exp.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, b32.out_valid, 1);
            chk({tag, "_char"}, b32.out_char, exp[k]);
            chk({tag, "_busy"}, b32.busy, 1);
            chk({tag, "_inrdy"}, b32.in_ready, 0);
            b32.out_ready = !stall || (i % 2 == 0);
            b32.in_valid  = inject && (i == 2);
            b32.in_data   = 32'h12345678;
            if (b32.out_ready) k++;
            @(negedge clk);
        end
        b32.in_valid = 1'b0;
        chk({tag, "_end_valid"}, b32.out_valid, 0);
        chk({tag, "_end_busy"}, b32.busy, 0);
        chk({tag, "_end_inrdy"}, b32.in_ready, 1);
        @(negedge clk);
        chk({tag, "_idle_valid"}, b32.out_valid, 0);
        chk({tag, "_idle_busy"}, b32.busy, 0);
    endtask
    initial begin
        logic [7:0] q[$];
        {b32.in_valid, b32.out_ready, b8.in_valid, b8.out_ready, b4.in_valid, b4.out_ready} = '0;
        b32.in_data = '0;
        b8.in_data  = '0;
        b4.in_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_inrdy", b32.in_ready, 0);
        chk("rst_valid", b32.out_valid, 0);
        chk("rst_char", b32.out_char, 8'h00);
        chk("rst_busy", b32.busy, 0);
        rst = 1'b0;
        #1 chk("rst_rel_inrdy", b32.in_ready, 1);
        b32.out_ready = 1'b1;
        @(negedge clk);
        chk("ready_no_valid", b32.out_valid, 0);
        send32(32'hDEADBEEF);
        q = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0A};
        recv32("deadbeef", q, 1'b0, 1'b0);
        send32(32'h0000000A);
        q = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h41, 8'h0A};
        recv32("stall", q, 1'b1, 1'b0);
        send32(32'hFFFFFFFF);
        q = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h0A};
        recv32("ignore", q, 1'b0, 1'b1);
        send32(32'hCAFEF00D);
        b32.out_ready = 1'b1;
        q = '{8'h43, 8'h41, 8'h46};
        for (int i = 0; i < 3; i++) begin
            chk("abort_char", b32.out_char, q[i]);
            @(negedge clk);
        end
        chk("abort_pre_char", b32.out_char, 8'h45);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", b32.out_valid, 0);
        chk("abort_busy", b32.busy, 0);
        chk("abort_inrdy", b32.in_ready, 0);
        rst = 1'b0;
        send32(32'h00000001);
        q = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0A};
        recv32("after_rst", q, 1'b0, 1'b0);
`ifdef HEX_WORD_STREAMER_PREFIX_EN
        q = '{8'h30, 8'h78, 8'h37, 8'h46, 8'h0A};
`else
        q = '{8'h37, 8'h46, 8'h0A};
`endif
        b8.in_valid  = 1'b1;
        b8.in_data   = 8'h7F;
        b8.out_ready = 1'b1;
        @(negedge clk);
        b8.in_valid = 1'b0;
        foreach (q[i]) begin
            chk("w8_valid", b8.out_valid, 1);
            chk("w8_char", b8.out_char, q[i]);
            @(negedge clk);
        end
        chk("w8_end_valid", b8.out_valid, 0);
        chk("w8_end_inrdy", b8.in_ready, 1);
        q = '{8'h39, 8'h20};
        b4.in_valid  = 1'b1;
        b4.in_data   = 4'h9;
        b4.out_ready = 1'b1;
        @(negedge clk);
        b4.in_valid = 1'b0;
        foreach (q[i]) begin
            chk("w4_valid", b4.out_valid, 1);
            chk("w4_char", b4.out_char, q[i]);
            @(negedge clk);
        end
        chk("w4_end_valid", b4.out_valid, 0);
        chk("w4_end_busy", b4.busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hex_word_streamer.md
Name: hex_word_streamer

Overview:
Serialises one DATA_WIDTH-bit word into a stream of ASCII hex characters, most-significant nibble first, followed by a separator character. It sits between debug capture logic (register or bus snoop) and the debug UART transmitter. It drives each nibble through the existing hextoascii converter and presents one character per valid/ready handshake.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 4 and at least 4.
SEPARATOR, 8'h0A, ASCII byte emitted after the last digit of every word.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  word available on in_data
in_data  input  DATA_WIDTH  word to print
in_ready  output  1  block can accept a word; high only in IDLE
out_valid  output  1  out_char holds a valid character
out_char  output  8  ASCII character
out_ready  input  1  downstream accepts out_char this cycle
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset values: state IDLE, out_valid 0, out_char 8'h00, busy 0, shift register 0, digit counter 0. in_ready is 0 while rst is high and 1 in the first cycle after reset is released.
- in_ready is decoded combinationally from state: in_ready = (state == IDLE) && !rst.
- Accept: in_valid && in_ready at an edge latches in_data into the shift register and loads digit counter = DATA_WIDTH/4 - 1.
  - With the macro undefined, the next state is DIGIT.
  - out_valid rises the cycle after acceptance: 1-cycle latency to the first character.
- States: IDLE, PFX0, PFX1 (PFX0/PFX1 exist only with the macro defined), DIGIT, SEP.
- DIGIT:
  - out_char = hextoascii(shift[DATA_WIDTH-1 -: 4]); uppercase A-F.
  - On handshake: shift left by 4 and decrement the counter.
  - When the counter is 0 at handshake, go to SEP.
- SEP: out_char = SEPARATOR; on handshake go to IDLE with out_valid 0.
- Handshake rules:
  - out_char and out_valid are registered and stay stable while out_valid && !out_ready.
  - Back-to-back handshakes give one character per cycle.
  - Per word, cycle cost = character count + 1 (the IDLE accept cycle); accept never overlaps output.
- Boundaries:
  - in_valid while busy is ignored, with no latching.
  - A word of all zeros prints every digit; there is no zero suppression.
  - out_ready held 0 stalls the stream indefinitely with no loss.
  - out_ready asserted with out_valid 0 has no effect.
  - rst asserted mid-word aborts the word: the remaining characters are discarded, and out_valid is 0 in the cycle after rst is sampled.
  - DATA_WIDTH = 4: counter loads 0, giving a single digit followed by SEP.
- Counter width: $clog2(DATA_WIDTH/4), minimum 1 bit.

Optional Feature:
HEX_WORD_STREAMER_PREFIX_EN
- Defined: after accept, the FSM goes IDLE->PFX0->PFX1->DIGIT. PFX0 emits "0" (8'h30) and PFX1 emits "x" (8'h78), each on its own handshake. Per-word output = 2 + DATA_WIDTH/4 + 1 characters.
- Undefined: PFX states are not compiled in; behaviour is as in Behaviour above.

Decomposition:
- Package hexdump_pkg holds:
  - state enum (IDLE, PFX0, PFX1, DIGIT, SEP)
  - ASCII constants ASCII_ZERO 8'h30, ASCII_X 8'h78, ASCII_LF 8'h0A
- Sub-module: one instance of the existing hextoascii, fed by the top nibble of the shift register. No other sub-modules.

Test Plan:
1. Macro off, in_data 32'hDEADBEEF, out_ready tied 1 -> chars 44 45 41 44 42 45 45 46 0A on 9 consecutive cycles. First char appears 1 cycle after accept; in_ready returns 1 the cycle after the 0A handshake.
2. in_data 32'h0000000A, out_ready toggling 1,0,1,0 -> seven 30 then 41 then 0A. out_char stays stable through every stall cycle; no char is duplicated or dropped.
3. Second in_valid with 32'h12345678 pulsed while printing 32'hFFFFFFFF -> the second word is ignored; output is eight 46 then 0A, and busy is 1 throughout.
4. rst asserted after the 3rd handshake of 32'hCAFEF00D -> out_valid 0 and busy 0 the next cycle. After release, word 32'h1 prints "00000001\n" correctly.
5. Macro on, DATA_WIDTH=8, in_data 8'h7F -> chars 30 78 37 46 0A, then IDLE.
6. SEPARATOR=8'h20, DATA_WIDTH=4, in_data 4'h9 -> chars 39 20.
